pico_ctrl: RTL and testbench

Multi-cycle control FSM for the pico-MIPS core. It sequences instruction fetch, decode, execute and writeback around the shared ALU. It decodes a 4-bit opcode into ALU function codes (the codebase's alucodes macros), register-file write enable, immediate select, PC increment/load and I/O strobes. It uses the ALU zero flag to resolve conditional branches.

---
 rtl/pico_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pico_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pico_ctrl.sv
// pico_ctrl: multi-cycle fetch/decode/exec/wb control FSM for pico-MIPS.
// Define CTRL_HALT_EN to make HALT stop the core until reset.
package pico_pkg;
  localparam logic [2:0] RA   = 3'b000;
  localparam logic [2:0] RB   = 3'b001;
  localparam logic [2:0] RADD = 3'b010;
  localparam logic [2:0] RSUB = 3'b011;
  localparam logic [2:0] RAND = 3'b100;
  localparam logic [2:0] ROR  = 3'b101;
  localparam logic [2:0] RXOR = 3'b110;
  localparam logic [2:0] RNOR = 3'b111;
endpackage

module pico_ctrl
  import pico_pkg::*;
#(
  parameter int OPW = 4,
  parameter int FW  = 3
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           instr_valid,
  input  logic [OPW-1:0] opcode,
  input  logic           zf,
  output logic           ir_load,
  output logic [FW-1:0]  alu_func,
  output logic           imm_sel,
  output logic           in_sel,
  output logic           reg_we,
  output logic           pc_en,
  output logic           pc_load,
  output logic           out_we,
  output logic           halted
);

  localparam logic [OPW-1:0] OP_NOP  = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_MOV  = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'hA);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(4'hB);
  localparam logic [OPW-1:0] OP_J    = OPW'(4'hC);
  localparam logic [OPW-1:0] OP_IN   = OPW'(4'hD);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(4'hE);
  localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_BRANCH,
    S_HALT
  } state_e;

  typedef struct packed {
    logic [FW-1:0] alu_func;
    logic          imm_sel;
    logic          in_sel;
    logic          reg_we;
    logic          pc_en;
    logic          pc_load;
    logic          out_we;
    logic          halted;
  } ctrl_t;

  localparam ctrl_t CTL_RST = {FW'(RA), 7'b0};

  state_e         state, nstate;
  logic [OPW-1:0] op_q, nop;
  logic           zf_q, nzf;
  ctrl_t          ctl_q;

  function automatic state_e exec_next(
    input logic [OPW-1:0] op
  );
    state_e n;
    n = S_FETCH;
    unique case (1'b1)
      (op >= OP_ADD && op <= OP_LDI),
      (op == OP_IN):  n = S_WB;
      (op == OP_BEQ),
      (op == OP_BNE): n = S_BRANCH;
`ifdef CTRL_HALT_EN
      (op == OP_HALT): n = S_HALT;
`endif
      default: n = S_FETCH;
    endcase
    return n;
  endfunction

  // Control word for the cycle spent in state s with opcode op.
  function automatic ctrl_t decode(
    input state_e         s,
    input logic [OPW-1:0] op,
    input logic           z
  );
    ctrl_t c;
    logic  taken;
    c = CTL_RST;
    taken = ((op == OP_BEQ) && z) ||
            ((op == OP_BNE) && !z);
    unique case (s)
      S_EXEC, S_WB: begin
        unique case (1'b1)
          (op == OP_ADD): c.alu_func = FW'(RADD);
          (op == OP_ADDI): begin
            c.alu_func = FW'(RADD);
            c.imm_sel  = 1'b1;
          end
          (op == OP_SUB): c.alu_func = FW'(RSUB);
          (op == OP_AND): c.alu_func = FW'(RAND);
          (op == OP_OR):  c.alu_func = FW'(ROR);
          (op == OP_XOR): c.alu_func = FW'(RXOR);
          (op == OP_NOR): c.alu_func = FW'(RNOR);
          (op == OP_MOV): c.alu_func = FW'(RB);
          (op == OP_LDI): begin
            c.alu_func = FW'(RB);
            c.imm_sel  = 1'b1;
          end
          (op == OP_IN):  c.in_sel = 1'b1;
          (op == OP_BEQ),
          (op == OP_BNE): c.alu_func = FW'(RSUB);
          (op == OP_J):   c.pc_load = 1'b1;
          (op == OP_OUT): begin
            c.out_we = 1'b1;
            c.pc_en  = 1'b1;
          end
`ifdef CTRL_HALT_EN
          (op == OP_HALT): c.pc_en = 1'b0;
`endif
          default: c.pc_en = 1'b1;
        endcase
        // WB is only entered by register-writing ops.
        if (s == S_WB) begin
          c.reg_we = 1'b1;
          c.pc_en  = 1'b1;
        end
      end
      S_BRANCH: begin
        c.pc_load = taken;
        c.pc_en   = !taken;
      end
      S_HALT: c.halted = 1'b1;
      default: c = CTL_RST;
    endcase
    return c;
  endfunction

  always_comb begin
    nstate = state;
    nop    = op_q;
    nzf    = zf_q;
    unique case (state)
      S_FETCH: begin
        if (instr_valid) nstate = S_DECODE;
      end
      S_DECODE: begin
        nop    = opcode;
        nstate = S_EXEC;
      end
      S_EXEC: begin
        nzf    = zf;
        nstate = exec_next(op_q);
      end
      S_WB:     nstate = S_FETCH;
      S_BRANCH: nstate = S_FETCH;
      S_HALT:   nstate = S_HALT;
      default:  nstate = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= S_FETCH;
      op_q  <= OP_NOP;
      zf_q  <= 1'b0;
      ctl_q <= CTL_RST;
    end else begin
      state <= nstate;
      op_q  <= nop;
      zf_q  <= nzf;
      ctl_q <= decode(nstate, nop, nzf);
    end
  end

  assign ir_load  = n_reset && (state == S_FETCH) && instr_valid;
  assign alu_func = ctl_q.alu_func;
  assign imm_sel  = ctl_q.imm_sel;
  assign in_sel   = ctl_q.in_sel;
  assign reg_we   = ctl_q.reg_we;
  assign pc_en    = ctl_q.pc_en;
  assign pc_load  = ctl_q.pc_load;
  assign out_we   = ctl_q.out_we;
  assign halted   = ctl_q.halted;

endmodule

// File: tb/tb_pico_ctrl.sv
// tb_pico_ctrl: random instruction streams checked against a
// per-instruction cycle-schedule model of the control FSM.
module tb_pico_ctrl;

  localparam logic [2:0] A_RA   = 3'b000;
  localparam logic [2:0] A_RB   = 3'b001;
  localparam logic [2:0] A_RADD = 3'b010;
  localparam logic [2:0] A_RSUB = 3'b011;
  localparam logic [2:0] A_RAND = 3'b100;
  localparam logic [2:0] A_ROR  = 3'b101;
  localparam logic [2:0] A_RXOR = 3'b110;
  localparam logic [2:0] A_RNOR = 3'b111;

`ifdef CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_reset;
  logic       instr_valid;
  logic [3:0] opcode;
  logic       zf;
  logic       ir_load;
  logic [2:0] alu_func;
  logic       imm_sel;
  logic       in_sel;
  logic       reg_we;
  logic       pc_en;
  logic       pc_load;
  logic       out_we;
  logic       halted;

  int checks = 0;
  int errors = 0;

  pico_ctrl #(.OPW(4), .FW(3)) dut (
    .clk(clk),
    .n_reset(n_reset),
    .instr_valid(instr_valid),
    .opcode(opcode),
    .zf(zf),
    .ir_load(ir_load),
    .alu_func(alu_func),
    .imm_sel(imm_sel),
    .in_sel(in_sel),
    .reg_we(reg_we),
    .pc_en(pc_en),
    .pc_load(pc_load),
    .out_we(out_we),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {ir_load, alu_func, imm_sel, in_sel,
                reg_we, pc_en, pc_load, out_we, halted};

  function automatic logic [10:0] mk(
    input logic ir, input logic [2:0] alu,
    input logic imm, input logic ins, input logic we,
    input logic pce, input logic pcl, input logic ow,
    input logic h
  );
    return {ir, alu, imm, ins, we, pce, pcl, ow, h};
  endfunction

  localparam logic [10:0] IDLE = 11'b0;

  task automatic chk(
    input string tag,
    input logic [10:0] got,
    input logic [10:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic tick(
    input logic iv, input logic [3:0] opc,
    input logic z, input logic [10:0] e,
    input string tag
  );
    @(negedge clk);
    instr_valid = iv;
    opcode = opc;
    zf = z;
    #1;
    chk(tag, obs, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    instr_valid = 1'b1;
    #1;
    chk("reset", obs, IDLE);
    @(negedge clk);
    #1;
    chk("reset_hold", obs, IDLE);
    @(negedge clk);
    n_reset = 1'b1;
    instr_valid = 1'b0;
  endtask

  // EXEC-cycle control word from the opcode table.
  function automatic logic [10:0] exec_vec(input logic [3:0] op);
    case (op)
      4'h1: return mk(0, A_RADD, 0, 0, 0, 0, 0, 0, 0);
      4'h2: return mk(0, A_RADD, 1, 0, 0, 0, 0, 0, 0);
      4'h3: return mk(0, A_RSUB, 0, 0, 0, 0, 0, 0, 0);
      4'h4: return mk(0, A_RAND, 0, 0, 0, 0, 0, 0, 0);
      4'h5: return mk(0, A_ROR, 0, 0, 0, 0, 0, 0, 0);
      4'h6: return mk(0, A_RXOR, 0, 0, 0, 0, 0, 0, 0);
      4'h7: return mk(0, A_RNOR, 0, 0, 0, 0, 0, 0, 0);
      4'h8: return mk(0, A_RB, 0, 0, 0, 0, 0, 0, 0);
      4'h9: return mk(0, A_RB, 1, 0, 0, 0, 0, 0, 0);
      4'hA, 4'hB:
            return mk(0, A_RSUB, 0, 0, 0, 0, 0, 0, 0);
      4'hC: return mk(0, A_RA, 0, 0, 0, 0, 1, 0, 0);
      4'hD: return mk(0, A_RA, 0, 1, 0, 0, 0, 0, 0);
      4'hE: return mk(0, A_RA, 0, 0, 0, 1, 0, 1, 0);
      4'hF: return HALT_EN ? IDLE :
                   mk(0, A_RA, 0, 0, 0, 1, 0, 0, 0);
      default: return mk(0, A_RA, 0, 0, 0, 1, 0, 0, 0);
    endcase
  endfunction

  task automatic run_instr(
    input logic [3:0] op,
    input logic zfe,
    input bit abort_wb
  );
    logic [10:0] q[$];
    logic [10:0] ex;
    logic taken;
    bit is_wb;
    bit is_br;
    is_wb = (op >= 4'h1 && op <= 4'h9) || op == 4'hD;
    is_br = (op == 4'hA) || (op == 4'hB);
    taken = (op == 4'hA) ? zfe : !zfe;
    ex = exec_vec(op);
    q.push_back(mk(1, A_RA, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(IDLE);
    q.push_back(ex);
    if (is_wb) q.push_back(ex | 11'b000_0001_1000);
    if (is_br)
      q.push_back(mk(0, A_RA, 0, 0, 0, !taken, taken, 0, 0));
    for (int i = 0; i < q.size(); i++)
      tick(i == 0 ? 1'b1 : 1'($urandom),
           i == 1 ? op : 4'($urandom),
           i == 2 ? zfe : 1'($urandom),
           q[i],
           $sformatf("op%h z%0d c%0d", op, zfe, i));
    if (abort_wb) begin
      #1;
      instr_valid = 1'b1;
      n_reset = 1'b0;
      #1;
      chk("abort_wb", obs, IDLE);
      @(negedge clk);
      n_reset = 1'b1;
      instr_valid = 1'b0;
    end
    if (HALT_EN && op == 4'hF) begin
      for (int i = 0; i < 20; i++)
        tick(1'($urandom), 4'($urandom), 1'($urandom),
             mk(0, A_RA, 0, 0, 0, 0, 0, 0, 1),
             $sformatf("halt c%0d", i));
      do_reset();
    end
  endtask

  initial begin
    n_reset = 1'b0;
    instr_valid = 1'b0;
    opcode = 4'h0;
    zf = 1'b0;
    @(negedge clk);
    #1;
    chk("por", obs, IDLE);
    do_reset();
    for (int i = 0; i < 5; i++)
      tick(1'b0, 4'($urandom), 1'($urandom), IDLE,
           $sformatf("idle c%0d", i));
    for (int op = 0; op < 16; op++)
      for (int z = 0; z < 2; z++) begin
        run_instr(4'(op), 1'(z), 1'b0);
        tick(1'b0, 4'($urandom), 1'($urandom), IDLE, "gap");
      end
    run_instr(4'h1, 1'b0, 1'b1);
    tick(1'b0, 4'h0, 1'b0, IDLE, "post_abort");
    for (int n = 0; n < 40; n++) begin
      run_instr(4'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2))
        tick(1'b0, 4'($urandom), 1'($urandom), IDLE, "rgap");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
